capture_scheduler: RTL and testbench

- Run controller that sequences the 12-bit ADC reader and the Arduino writer for one capture run.
- Issues paced ADC conversion requests and buffers returned samples in an internal FIFO.
- Drains the FIFO to the Arduino writer concurrently with collection, one sample per write transaction.
- Replaces the fixed collect-all-then-send sequencing with overlapped, paced, abortable runs and host-visible status.

---
 rtl/capture_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_capture_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_scheduler.sv
// capture_scheduler: sequences one capture run between the 12-bit ADC reader
// and the Arduino writer. ADC requests are paced by a programmable interval,
// returned samples are buffered in a FIFO, and the FIFO is drained to the
// writer while collection is still in progress. A run can be aborted at any
// time, and per-run progress counters are left readable afterwards.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   start, abort       run control (start accepted only when idle)
//   num_samples        conversions per run, latched at start
//   interval           clk cycles between adc_start pulses, latched at start
//   adc_start/_done    ADC reader handshake, adc_data returned sample
//   ard_start/_done    Arduino writer handshake, ard_data outgoing sample
//   busy, done         run in progress / one-cycle normal completion pulse
//   overflow           sticky: a sample was dropped this run
//   collected          conversions completed this run
//   transmitted        samples acknowledged by the writer this run
module capture_scheduler #(
   parameter int unsigned SAMPLE_W   = 12,
   parameter int unsigned DEPTH      = 128,  // power of two, at least 2
   parameter int unsigned CNT_W      = 7,
   parameter int unsigned INTERVAL_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_W-1:0]      num_samples,
   input  logic [INTERVAL_W-1:0] interval,
   output logic                  adc_start,
   input  logic                  adc_done,
   input  logic [SAMPLE_W-1:0]   adc_data,
   output logic                  ard_start,
   output logic [SAMPLE_W-1:0]   ard_data,
   input  logic                  ard_done,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [CNT_W-1:0]      collected,
   output logic [CNT_W-1:0]      transmitted
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [CNT_W-1:0]      collected_q, collected_d;
   logic [CNT_W-1:0]      transmitted_q, transmitted_d;
   logic [INTERVAL_W-1:0] interval_q, interval_d;
   logic [INTERVAL_W-1:0] timer_q, timer_d;
   logic                  adc_pend_q, adc_pend_d;
   logic                  ard_pend_q, ard_pend_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]     count_q, count_d;
   logic                  adc_start_q, adc_start_d;
   logic                  ard_start_q, ard_start_d;
   logic [SAMPLE_W-1:0]   ard_data_q, ard_data_d;
   logic                  busy_q;
   logic                  done_q, done_d;
   logic                  overflow_q, overflow_d;
   logic                  push, pop;
   logic [SAMPLE_W-1:0]   mem_q [DEPTH];

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      interval_d    = interval_q;
      timer_d       = timer_q;
      collected_d   = collected_q;
      transmitted_d = transmitted_q;
      adc_pend_d    = adc_pend_q;
      ard_pend_d    = ard_pend_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      ard_data_d    = ard_data_q;
      overflow_d    = overflow_q;
      adc_start_d   = 1'b0;
      ard_start_d   = 1'b0;
      done_d        = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (num_samples != '0) begin
                  n_d           = num_samples;
                  interval_d    = interval;
                  collected_d   = '0;
                  transmitted_d = '0;
                  overflow_d    = 1'b0;
                  wr_ptr_d      = '0;
                  rd_ptr_d      = '0;
                  count_d       = '0;
                  // First conversion is requested together with the accept.
                  adc_start_d   = 1'b1;
                  adc_pend_d    = 1'b1;
                  timer_d       = interval;
                  state_d       = StRun;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StRun: begin
            if (collected_q == n_q && !adc_pend_q && !ard_pend_q && count_q == '0) begin
               state_d = StFin;
            end else begin
               if (timer_q != '0) timer_d = timer_q - INTERVAL_W'(1);
               pop = !ard_pend_q && (count_q != '0);
               if (adc_done && adc_pend_q) begin
                  adc_pend_d = 1'b0;
                  if (collected_q != n_q) collected_d = collected_q + CNT_W'(1);
                  // A full FIFO still accepts when its head leaves this cycle.
                  if (count_q != FCNT_W'(DEPTH) || pop) push = 1'b1;
                  else overflow_d = 1'b1;
               end
               if (ard_done && ard_pend_q) begin
                  ard_pend_d    = 1'b0;
                  transmitted_d = transmitted_q + CNT_W'(1);
               end
               if (pop) begin
                  ard_data_d  = mem_q[rd_ptr_q];
                  ard_start_d = 1'b1;
                  ard_pend_d  = 1'b1;
               end
               // timer_q <= 1 means it reaches zero this cycle, so pulses land
               // exactly 'interval' cycles apart; a completing conversion frees
               // the ADC in the same cycle.
               if (timer_q <= INTERVAL_W'(1) && !adc_pend_d && collected_d < n_q) begin
                  adc_start_d = 1'b1;
                  adc_pend_d  = 1'b1;
                  timer_d     = interval_q;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + FCNT_W'(1);
      else if (pop && !push) count_d = count_q - FCNT_W'(1);

      // Abort wins over everything; progress counters stay for readout.
      if (abort) begin
         state_d       = StIdle;
         adc_start_d   = 1'b0;
         ard_start_d   = 1'b0;
         done_d        = 1'b0;
         adc_pend_d    = 1'b0;
         ard_pend_d    = 1'b0;
         timer_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         push          = 1'b0;
         pop           = 1'b0;
         collected_d   = collected_q;
         transmitted_d = transmitted_q;
         overflow_d    = overflow_q;
         ard_data_d    = ard_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         n_q           <= '0;
         interval_q    <= '0;
         timer_q       <= '0;
         collected_q   <= '0;
         transmitted_q <= '0;
         adc_pend_q    <= 1'b0;
         ard_pend_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         adc_start_q   <= 1'b0;
         ard_start_q   <= 1'b0;
         ard_data_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         interval_q    <= interval_d;
         timer_q       <= timer_d;
         collected_q   <= collected_d;
         transmitted_q <= transmitted_d;
         adc_pend_q    <= adc_pend_d;
         ard_pend_q    <= ard_pend_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         adc_start_q   <= adc_start_d;
         ard_start_q   <= ard_start_d;
         ard_data_q    <= ard_data_d;
         busy_q        <= (state_d == StRun);
         done_q        <= done_d;
         overflow_q    <= overflow_d;
      end
   end

   // Sample storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= adc_data;
   end

   assign adc_start   = adc_start_q;
   assign ard_start   = ard_start_q;
   assign ard_data    = ard_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign collected   = collected_q;
   assign transmitted = transmitted_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Bench for capture_scheduler: directed runs with ADC / Arduino responders, a
// transaction-level reference model compared every cycle, and literal checks.
module tb_capture_scheduler;

   localparam int unsigned SW = 12;
   localparam int unsigned DP = 4;
   localparam int unsigned CW = 7;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort, adc_done, ard_done;
   logic [CW-1:0] num_samples;
   logic [IW-1:0] interval;
   logic [SW-1:0] adc_data;
   logic          adc_start, ard_start, busy, done, overflow;
   logic [SW-1:0] ard_data;
   logic [CW-1:0] collected, transmitted;
   logic [30:0]   dut_vec;

   capture_scheduler #(
      .SAMPLE_W(SW), .DEPTH(DP), .CNT_W(CW), .INTERVAL_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .num_samples(num_samples), .interval(interval),
      .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
      .ard_start(ard_start), .ard_data(ard_data), .ard_done(ard_done),
      .busy(busy), .done(done), .overflow(overflow),
      .collected(collected), .transmitted(transmitted)
   );

   always #5 clk = ~clk;

   assign dut_vec = {adc_start, ard_start, ard_data, busy, done, overflow, collected, transmitted};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef enum int {MIdle, MRun, MFin} mphase_e;
   mphase_e     ph;
   int unsigned m_n, m_iv, e_coll, e_tx, m_drops;
   longint      mcyc, last_issue;
   bit          m_adc_pend, m_ard_pend, sending;
   bit          e_adc_start, e_ard_start, e_done, e_ovf, e_busy;
   logic [SW-1:0] e_ard_data, head;
   logic [SW-1:0] mq[$];

   task automatic model_reset();
      ph = MIdle; m_n = 0; m_iv = 0; e_coll = 0; e_tx = 0; m_drops = 0;
      mcyc = 0; last_issue = 0; m_adc_pend = 0; m_ard_pend = 0;
      e_adc_start = 0; e_ard_start = 0; e_done = 0; e_ovf = 0; e_busy = 0;
      e_ard_data = '0; mq.delete();
   endtask

   task automatic model_step();
      int unsigned gap;
      mcyc++;
      e_adc_start = 0; e_ard_start = 0; e_done = 0;
      if (abort) begin
         ph = MIdle; mq.delete(); m_adc_pend = 0; m_ard_pend = 0;
      end else begin
         case (ph)
            MIdle: if (start) begin
               if (num_samples != '0) begin
                  m_n = num_samples; m_iv = interval;
                  e_coll = 0; e_tx = 0; e_ovf = 0; m_drops = 0; mq.delete();
                  e_adc_start = 1; m_adc_pend = 1; last_issue = mcyc;
                  ph = MRun;
               end else ph = MFin;
            end
            MRun: begin
               if (e_coll == m_n && !m_adc_pend && !m_ard_pend && mq.size() == 0) begin
                  ph = MFin;
               end else begin
                  sending = !m_ard_pend && mq.size() != 0;
                  if (sending) head = mq.pop_front();
                  if (adc_done && m_adc_pend) begin
                     m_adc_pend = 0; e_coll++;
                     if (mq.size() < int'(DP)) mq.push_back(adc_data);
                     else begin e_ovf = 1; m_drops++; end
                  end
                  if (ard_done && m_ard_pend) begin m_ard_pend = 0; e_tx++; end
                  if (sending) begin e_ard_start = 1; e_ard_data = head; m_ard_pend = 1; end
                  gap = (m_iv == 0) ? 1 : m_iv;
                  if (!m_adc_pend && e_coll < m_n && (mcyc - last_issue) >= longint'(gap)) begin
                     e_adc_start = 1; m_adc_pend = 1; last_issue = mcyc;
                  end
               end
            end
            default: begin e_done = 1; ph = MIdle; end
         endcase
      end
      e_busy = (ph == MRun);
   endtask

   function automatic logic [30:0] mod_vec();
      return {e_adc_start, e_ard_start, e_ard_data, e_busy, e_done, e_ovf, CW'(e_coll), CW'(e_tx)};
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   // Single compare process: every cycle out of reset.
   initial forever begin
      @(negedge clk);
      if (rst === 1'b1) chk("cycle", 64'(dut_vec), 64'(mod_vec()));
   end

   // ---------------- environment ----------------
   longint        tcyc = 0, c0 = 0, adc_due = -1, ard_due = -1;
   int            adc_lat, ard_lat, adc_starts, ard_starts, done_pulses = 0;
   int unsigned   adc_val;
   longint        adc_t[$];
   logic [SW-1:0] ard_seen[$];

   task automatic tick();
      @(negedge clk);
      tcyc++;
      adc_done = 1'b0; ard_done = 1'b0; start = 1'b0; abort = 1'b0;
      if (done) done_pulses++;
      if (adc_start) begin adc_starts++; adc_t.push_back(tcyc); adc_due = tcyc + adc_lat; end
      if (ard_start) begin ard_starts++; ard_seen.push_back(ard_data); ard_due = tcyc + ard_lat; end
      if (tcyc == adc_due) begin adc_val++; adc_done = 1'b1; adc_data = SW'(adc_val); end
      if (tcyc == ard_due) ard_done = 1'b1;
   endtask

   task automatic begin_run(input int n, input int iv, input int alat, input int wlat);
      adc_t.delete(); ard_seen.delete();
      adc_starts = 0; ard_starts = 0; adc_val = 0;
      adc_lat = alat; ard_lat = wlat;
      num_samples = CW'(n); interval = IW'(iv); start = 1'b1;
      c0 = tcyc;
   endtask

   task automatic run_until_done(input string name, input int budget);
      int d0, n;
      d0 = done_pulses; n = 0;
      while (done_pulses == d0 && n < budget) begin tick(); n++; end
      repeat (4) tick();
      chk({name, "_done_once"}, 64'(done_pulses - d0), 64'(1));
   endtask

   task automatic chk_gaps(input string name, input int cnt, input longint gap);
      for (int i = 0; i < cnt; i++)
         chk(name, 64'((i + 1 < adc_t.size()) ? adc_t[i+1] - adc_t[i] : -1), 64'(gap));
   endtask

   task automatic chk_ard_seq(input string name, input int cnt);
      for (int i = 0; i < cnt; i++)
         chk(name, 64'((i < ard_seen.size()) ? ard_seen[i] : 12'hfff), 64'(i + 1));
   endtask

   initial begin
      int n, d0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; adc_done = 1'b0; ard_done = 1'b0;
      num_samples = '0; interval = '0; adc_data = '0; adc_lat = 1; ard_lat = 1;
      repeat (3) tick();
      chk("reset_outputs", 64'(dut_vec), 64'(0));
      rst = 1'b1;
      tick();

      // Basic paced run.
      begin_run(4, 50, 10, 20);
      run_until_done("basic", 1000);
      chk("basic_first_adc", 64'((adc_t.size() > 0) ? adc_t[0] - c0 : -1), 64'(1));
      chk("basic_adc_count", 64'(adc_starts), 64'(4));
      chk_gaps("basic_adc_gap", 3, 50);
      chk_ard_seq("basic_ard_data", 4);
      chk("basic_collected", 64'(collected), 64'(4));
      chk("basic_transmitted", 64'(transmitted), 64'(4));
      chk("basic_overflow", 64'(overflow), 64'(0));

      // Zero-sample run.
      begin_run(0, 7, 10, 20);
      tick();
      chk("zero_done_early", 64'(done), 64'(0));
      chk("zero_busy", 64'(busy), 64'(0));
      tick();
      chk("zero_done_two_cycles", 64'(done), 64'(1));
      repeat (4) tick();
      chk("zero_no_adc", 64'(adc_starts), 64'(0));
      chk("zero_no_ard", 64'(ard_starts), 64'(0));

      // Overflow with a stalled writer: samples 6..10 are dropped.
      begin_run(10, 0, 2, 500);
      run_until_done("ovf", 4000);
      chk_gaps("ovf_adc_gap", 3, 3);
      chk("ovf_overflow", 64'(overflow), 64'(1));
      chk("ovf_collected", 64'(collected), 64'(10));
      chk("ovf_transmitted", 64'(transmitted), 64'(5));
      chk("ovf_relation", 64'(int'(transmitted)), 64'(int'(collected) - int'(m_drops)));
      chk_ard_seq("ovf_ard_data", 5);

      // Full FIFO receives a sample in the same cycle its head is popped.
      begin_run(6, 0, 2, 12);
      run_until_done("bp", 500);
      chk("bp_overflow", 64'(overflow), 64'(0));
      chk("bp_collected", 64'(collected), 64'(6));
      chk("bp_transmitted", 64'(transmitted), 64'(6));
      chk_ard_seq("bp_ard_data", 6);

      // Abort with a conversion outstanding.
      begin_run(100, 4, 2, 1);
      n = 0;
      while (!(collected == CW'(37) && adc_start) && n < 2000) begin tick(); n++; end
      chk("abort_reached_37", 64'(collected), 64'(37));
      d0 = done_pulses;
      abort = 1'b1;
      tick();
      chk("abort_busy_low", 64'(busy), 64'(0));
      repeat (6) tick();
      chk("abort_collected_hold", 64'(collected), 64'(37));
      chk("abort_no_done", 64'(done_pulses - d0), 64'(0));
      begin_run(3, 2, 2, 1);
      tick();
      chk("restart_cleared", 64'(collected), 64'(0));
      chk("restart_busy", 64'(busy), 64'(1));
      run_until_done("restart", 500);
      chk("restart_collected", 64'(collected), 64'(3));
      chk("restart_transmitted", 64'(transmitted), 64'(3));
      chk("restart_overflow", 64'(overflow), 64'(0));

      // Asynchronous reset while a write is outstanding.
      begin_run(5, 5, 3, 30);
      n = 0;
      while (!ard_start && n < 500) begin tick(); n++; end
      chk("rstmid_ard_started", 64'(ard_start), 64'(1));
      repeat (3) tick();
      #2 rst = 1'b0;
      #1 chk("rstmid_async_zero", 64'(dut_vec), 64'(0));
      repeat (2) tick();
      rst = 1'b1;
      repeat (40) tick();
      chk("rstmid_transmitted", 64'(transmitted), 64'(0));
      chk("rstmid_collected", 64'(collected), 64'(0));
      chk("rstmid_busy", 64'(busy), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1, "watchdog expired");
   end

endmodule
